id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the five-stage MIPS pipeline; the consuming end of the IF/ID latch. Takes the latched instruction and next-PC, reads the 32×32 register file, sign-extends the immediate, generates main control, detects load-use hazards, and registers everything into the ID/EX latch. The register file is written from the writeback stage through a dedicated port.

## Interface
Parameters:
- DATA_W, 32, datapath and register width
- REG_CNT, 32, architectural registers; register 0 reads as zero

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  32  instruction from IF/ID latch
- npc  in  32  next-PC from IF/ID latch
- wb_en  in  1  writeback register write enable
- wb_addr  in  5  writeback destination register
- wb_data  in  32  writeback data
- ex_memread  in  1  instruction currently in EX is a load
- ex_rt  in  5  rt field of instruction currently in EX
- flush  in  1  squash the instruction being decoded (taken branch)
- stall  out  1  combinational; freezes PC and IF/ID latch
- npcout  out  32  registered npc
- rd1out, rd2out  out  32 each  registered rs / rt read data
- immout  out  32  registered sign-extended instr[15:0]
- rtout, rdout  out  5 each  registered instr[20:16], instr[15:11]
- regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch  out  1 each  registered control
- aluop  out  2  registered ALU op class

## Operation
- Decode fields: op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- Control by op: 000000 R-type → regdst=1, regwrite=1, aluop=10; 100011 lw → alusrc=1, memread=1, memtoreg=1, regwrite=1, aluop=00; 101011 sw → alusrc=1, memwrite=1, aluop=00; 000100 beq → branch=1, aluop=01; any other op → all control 0 (bubble).
- Register file: one write port (wb_en/wb_addr/wb_data, on rising edge), two async read ports. Writes to register 0 are ignored; reads of register 0 return 0.
- Write-through bypass: if wb_en and wb_addr==rs (nonzero), rd1 takes wb_data in the same cycle; likewise rd2 for rt.
- immout = {{16{imm[15]}}, imm}.
- Hazard: stall = ex_memread && ex_rt!=0 && (ex_rt==rs || ex_rt==rt). Evaluated regardless of opcode.
- On stall or flush: all ID/EX control outputs load 0 (bubble); data fields (npcout, rd1out, rd2out, immout, rtout, rdout) still load normally. Flush and stall together: bubble, stall still asserted.

## Timing
- Latency: one cycle; inputs sampled on rising clk edge appear on ID/EX outputs after that edge.
- stall is purely combinational from instr and ex_* in the same cycle; no registered stall state.
- rst_n low: immediately all ID/EX outputs 0 and all 32 registers 0, independent of clk; stall still reflects inputs (ex_memread is 0 out of reset in-system).
- rst_n release: first rising edge after deassertion latches normally.
- Write and read of the same register in the same cycle: read returns new data (bypass); register content updates at the edge.
- instr = 32'h00000000 decodes as R-type with rd=0: regwrite=1 to $0, architecturally harmless.

## Structure
- Shared package mips_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ), ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
- One sub-module: reg_file (32×32, two async reads with bypass, one sync write, async active-low clear). Control decode, sign extend, hazard logic and ID/EX register stay in id_stage.

## Test plan
- Reset: hold rst_n=0 mid-cycle with instr=32'h8C220004 → all outputs 0 immediately; after release, register reads return 0.
- Writeback then read: wb_en=1, wb_addr=2, wb_data=32'hDEADBEEF with instr=32'h00431020 (add $2,$2,$3) same cycle → next edge rd1out=DEADBEEF, regdst=1, regwrite=1, aluop=10, rdout=2.
- lw decode: instr=32'h8C22FFFC → immout=32'hFFFFFFFC, alusrc=1, memread=1, memtoreg=1, regwrite=1, rtout=2.
- Load-use: ex_memread=1, ex_rt=2, instr=32'h00431020 → stall=1 same cycle, next edge all control 0; ex_rt=0 → stall=0.
- Flush: instr=32'hAC220008 (sw), flush=1 → memwrite=0 at next edge, immout=32'h00000008.
- Register 0: wb_en=1, wb_addr=0, wb_data=32'h12345678, then read rs=0 → rd1out=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, ALU op classes and the ID/EX control bundle.
package mips_pkg;

    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        regdst: 1'b0, alusrc: 1'b0, memread: 1'b0, memwrite: 1'b0,
        memtoreg: 1'b0, regwrite: 1'b0, branch: 1'b0, aluop: 2'b00
    };

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bundle: IF/ID inputs, writeback and hazard inputs, ID/EX outputs.
interface id_stage_if #(
    parameter int DATA_W = 32
) ();
    import mips_pkg::*;

    logic [31:0]        instr;
    logic [DATA_W-1:0]  npc;
    logic               wb_en;
    logic [REG_AW-1:0]  wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               ex_memread;
    logic [REG_AW-1:0]  ex_rt;
    logic               flush;
    logic               stall;
    logic [DATA_W-1:0]  npcout;
    logic [DATA_W-1:0]  rd1out;
    logic [DATA_W-1:0]  rd2out;
    logic [DATA_W-1:0]  immout;
    logic [REG_AW-1:0]  rtout;
    logic [REG_AW-1:0]  rdout;
    logic               regdst;
    logic               alusrc;
    logic               memread;
    logic               memwrite;
    logic               memtoreg;
    logic               regwrite;
    logic               branch;
    logic [1:0]         aluop;

    modport slave (
        input  instr, npc, wb_en, wb_addr, wb_data, ex_memread, ex_rt, flush,
        output stall, npcout, rd1out, rd2out, immout, rtout, rdout,
        output regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch, aluop
    );

    modport master (
        output instr, npc, wb_en, wb_addr, wb_data, ex_memread, ex_rt, flush,
        input  stall, npcout, rd1out, rd2out, immout, rtout, rdout,
        input  regdst, alusrc, memread, memwrite, memtoreg, regwrite, branch, aluop
    );

endinterface

// File: rtl/reg_file.sv
// 32-entry register file: one synchronous write port, two async read ports
// with write-through bypass, register 0 hardwired to zero.
module reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    logic [DATA_W-1:0] regs_r [REG_CNT];

    // Register storage: async clear, writes to register 0 dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // Read port 1: same-cycle writeback wins over stored value.
    always_comb begin
        rd1 = '0;
        if (rs == 5'd0) begin
            rd1 = '0;
        end else if (wb_en && (wb_addr == rs)) begin
            rd1 = wb_data;
        end else begin
            rd1 = regs_r[rs];
        end
    end

    // Read port 2: same bypass rule as port 1.
    always_comb begin
        rd2 = '0;
        if (rt == 5'd0) begin
            rd2 = '0;
        end else if (wb_en && (wb_addr == rt)) begin
            rd2 = wb_data;
        end else begin
            rd2 = regs_r[rt];
        end
    end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register read, immediate extend, main control,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    id_stage_if.slave bus
);

    logic [5:0]        op_s;
    logic [REG_AW-1:0] rs_s;
    logic [REG_AW-1:0] rt_s;
    logic [REG_AW-1:0] rd_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    ctrl_t             ctrl_s;
    ctrl_t             ctrl_next_s;
    logic              stall_s;

    ctrl_t             ctrl_r;
    logic [DATA_W-1:0] npc_r;
    logic [DATA_W-1:0] rd1_r;
    logic [DATA_W-1:0] rd2_r;
    logic [DATA_W-1:0] imm_r;
    logic [REG_AW-1:0] rt_r;
    logic [REG_AW-1:0] rd_r;

    assign op_s  = bus.instr[31:26];
    assign rs_s  = bus.instr[25:21];
    assign rt_s  = bus.instr[20:16];
    assign rd_s  = bus.instr[15:11];
    assign imm_s = {{(DATA_W-16){bus.instr[15]}}, bus.instr[15:0]};

    reg_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .wb_en   (bus.wb_en),
        .wb_addr (bus.wb_addr),
        .wb_data (bus.wb_data),
        .rs      (rs_s),
        .rt      (rt_s),
        .rd1     (rd1_s),
        .rd2     (rd2_s)
    );

    // Main control decode; unknown opcodes become a bubble.
    always_comb begin
        ctrl_s = CTRL_NOP;
        case (op_s)
            OP_RTYPE: begin
                ctrl_s.regdst   = 1'b1;
                ctrl_s.regwrite = 1'b1;
                ctrl_s.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_s.alusrc   = 1'b1;
                ctrl_s.memread  = 1'b1;
                ctrl_s.memtoreg = 1'b1;
                ctrl_s.regwrite = 1'b1;
                ctrl_s.aluop    = ALUOP_ADD;
            end
            OP_SW: begin
                ctrl_s.alusrc   = 1'b1;
                ctrl_s.memwrite = 1'b1;
                ctrl_s.aluop    = ALUOP_ADD;
            end
            OP_BEQ: begin
                ctrl_s.branch   = 1'b1;
                ctrl_s.aluop    = ALUOP_SUB;
            end
            default: begin
                ctrl_s = CTRL_NOP;
            end
        endcase
    end

    // Load-use hazard is checked on raw fields, whatever the opcode.
    assign stall_s = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                     ((bus.ex_rt == rs_s) || (bus.ex_rt == rt_s));

    // Stall or flush inserts a bubble into the control half of ID/EX only.
    always_comb begin
        ctrl_next_s = CTRL_NOP;
        if (stall_s || bus.flush) begin
            ctrl_next_s = CTRL_NOP;
        end else begin
            ctrl_next_s = ctrl_s;
        end
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= CTRL_NOP;
            npc_r  <= '0;
            rd1_r  <= '0;
            rd2_r  <= '0;
            imm_r  <= '0;
            rt_r   <= 5'd0;
            rd_r   <= 5'd0;
        end else begin
            ctrl_r <= ctrl_next_s;
            npc_r  <= bus.npc;
            rd1_r  <= rd1_s;
            rd2_r  <= rd2_s;
            imm_r  <= imm_s;
            rt_r   <= rt_s;
            rd_r   <= rd_s;
        end
    end

    assign bus.stall    = stall_s;
    assign bus.npcout   = npc_r;
    assign bus.rd1out   = rd1_r;
    assign bus.rd2out   = rd2_r;
    assign bus.immout   = imm_r;
    assign bus.rtout    = rt_r;
    assign bus.rdout    = rd_r;
    assign bus.regdst   = ctrl_r.regdst;
    assign bus.alusrc   = ctrl_r.alusrc;
    assign bus.memread  = ctrl_r.memread;
    assign bus.memwrite = ctrl_r.memwrite;
    assign bus.memtoreg = ctrl_r.memtoreg;
    assign bus.regwrite = ctrl_r.regwrite;
    assign bus.branch   = ctrl_r.branch;
    assign bus.aluop    = ctrl_r.aluop;

endmodule

// File: tb/tb_id_stage.sv
// Directed plus light random bench for id_stage with a reference model and scoreboard.
module tb_id_stage;

    typedef struct packed {
        logic [31:0] npc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        regdst;
        logic        alusrc;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        regwrite;
        logic        branch;
        logic [1:0]  aluop;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] regs_m [32];
    exp_t        sb_q [$];

    id_stage_if #(.DATA_W(32)) bus ();

    id_stage #(.DATA_W(32), .REG_CNT(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t observed();
        exp_t o;
        o = {bus.npcout, bus.rd1out, bus.rd2out, bus.immout, bus.rtout, bus.rdout,
             bus.regdst, bus.alusrc, bus.memread, bus.memwrite, bus.memtoreg,
             bus.regwrite, bus.branch, bus.aluop};
        return o;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                                input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return regs_m[a];
    endfunction

    task automatic check_exp(input string tag, input exp_t obs, input exp_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // One decode cycle: drive, check stall, push expectation, clock, pop and compare.
    task automatic step(input string tag, input logic [31:0] i, input logic [31:0] n,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mr, input logic [4:0] ert, input logic fl);
        exp_t e;
        exp_t got;
        logic [4:0] rs;
        logic [4:0] rt;
        logic st;
        rs = i[25:21];
        rt = i[20:16];
        bus.instr = i; bus.npc = n; bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
        bus.ex_memread = mr; bus.ex_rt = ert; bus.flush = fl;
        #1;
        st = mr && (ert != 5'd0) && (ert == rs || ert == rt);
        check_bit({tag, "_stall"}, bus.stall, st);
        e = '0;
        e.npc = n;
        e.rd1 = model_read(rs, we, wa, wd);
        e.rd2 = model_read(rt, we, wa, wd);
        e.imm = {{16{i[15]}}, i[15:0]};
        e.rt  = rt;
        e.rd  = i[15:11];
        if (!st && !fl) begin
            case (i[31:26])
                6'b000000: begin e.regdst = 1'b1; e.regwrite = 1'b1; e.aluop = 2'b10; end
                6'b100011: begin e.alusrc = 1'b1; e.memread = 1'b1; e.memtoreg = 1'b1;
                                 e.regwrite = 1'b1; e.aluop = 2'b00; end
                6'b101011: begin e.alusrc = 1'b1; e.memwrite = 1'b1; e.aluop = 2'b00; end
                6'b000100: begin e.branch = 1'b1; e.aluop = 2'b01; end
                default:   e.aluop = 2'b00;
            endcase
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (we && wa != 5'd0) regs_m[wa] = wd;
        bus.wb_en = 1'b0;
        got = observed();
        n_tests++;
        assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: got empty scoreboard expected an entry", tag);
        end
        if (sb_q.size() > 0) check_exp(tag, got, sb_q.pop_front());
    endtask

    initial begin
        logic [5:0] ops [5];
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001101;
        for (int r = 0; r < 32; r++) regs_m[r] = 32'h0;
        bus.instr = 32'h8C220004; bus.npc = 32'h0; bus.wb_en = 1'b0; bus.wb_addr = 5'd0;
        bus.wb_data = 32'h0; bus.ex_memread = 1'b0; bus.ex_rt = 5'd0; bus.flush = 1'b0;
        #2;
        check_exp("reset_init", observed(), '0);
        check_bit("reset_stall", bus.stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step("wb_bypass_add", 32'h00431020, 32'h00000004, 1'b1, 5'd2, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
        step("rt_bypass",     32'h00431020, 32'h00000008, 1'b1, 5'd3, 32'h11111111, 1'b0, 5'd0, 1'b0);
        step("lw_decode",     32'h8C22FFFC, 32'h0000000C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        step("load_use_rs",   32'h00431020, 32'h00000010, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
        step("load_use_rt0",  32'h00431020, 32'h00000014, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
        step("load_use_rt",   32'h00431020, 32'h00000018, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        step("flush_sw",      32'hAC220008, 32'h0000001C, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        step("flush_stall",   32'hAC220008, 32'h00000020, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1);
        step("beq_decode",    32'h10430005, 32'h00000024, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        step("other_op",      32'h3443FFFF, 32'h00000028, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        step("wr_reg0",       32'h00001020, 32'h0000002C, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0);
        step("rd_reg0",       32'h00001020, 32'h00000030, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        step("zero_instr",    32'h00000000, 32'h00000034, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);

        // Mid-cycle asynchronous reset clears outputs and the register file.
        #2;
        bus.instr = 32'h8C220004;
        rst_n = 1'b0;
        #1;
        check_exp("reset_async", observed(), '0);
        for (int r = 0; r < 32; r++) regs_m[r] = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_rd", 32'h00431020, 32'h00000040, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            logic [31:0] ri;
            ri = {ops[$urandom_range(0, 4)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  16'($urandom)};
            step("random", ri, 32'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                 32'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 5) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
